// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SD SPI-mode card responder.
package sd_spi_pkg;

   localparam logic [5:0] CMD0   = 6'd0;
   localparam logic [5:0] CMD8   = 6'd8;
   localparam logic [5:0] CMD55  = 6'd55;
   localparam logic [5:0] ACMD41 = 6'd41;

   localparam int R1_IDLE_BIT    = 0;
   localparam int R1_ILLEGAL_BIT = 2;
   localparam int R1_CRC_ERR_BIT = 3;

   localparam int R1_LEN    = 8;
   localparam int R7_LEN    = 40;
   localparam int FRAME_LEN = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_CMD,
      ST_DECODE,
      ST_NCR_WAIT,
      ST_TX_RESP
   } resp_state_t;

   function automatic logic [7:0] r1_bit(input int pos);
      return 8'(1 << pos);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1). Asserting clear together with enable restarts
// the CRC with the current bit as the first message bit.
module sd_crc7 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [6:0] o_crc
);

   logic [6:0] r_crc;
   logic [6:0] w_base;
   logic       w_fb;

   assign w_base = i_clr ? 7'd0 : r_crc;
   assign w_fb   = i_bit ^ w_base[6];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_crc <= '0;
      end else if (i_en) begin
         r_crc <= {w_base[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
      end else if (i_clr) begin
         r_crc <= '0;
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SPI-mode responder for CMD0/CMD8/CMD55/ACMD41 initialisation.
// Define SD_RESP_CRC_CHECK_EN to verify the CRC7 of each received command.
module sd_spi_card_responder
   import sd_spi_pkg::*;
#(
   parameter int         NCR_CYCLES      = 8,
   parameter int         ACMD41_BUSY_CNT = 2,
   parameter logic [3:0] VHS_ACCEPT      = 4'b0001
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        card_ready,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg
);

   resp_state_t r_state;
   logic [47:0] r_shift;
   logic [5:0]  r_rx_cnt;
   logic [3:0]  r_ncr_cnt;
   logic [5:0]  r_tx_cnt;
   logic [5:0]  r_tx_len;
   logic [39:0] r_resp;
   logic        r_in_idle;
   logic        r_app_cmd;
   logic [7:0]  r_busy_cnt;
   logic        r_miso;
   logic        r_card_ready;
   logic        r_cmd_valid;
   logic [5:0]  r_cmd_index;
   logic [31:0] r_cmd_arg;

   logic        w_start;
   logic        w_frame_ok;
   logic        w_crc_ok;
   logic        w_busy;
   logic        w_acmd41;
   logic        w_r7;
   logic [5:0]  w_idx;
   logic [31:0] w_arg;
   logic [3:0]  w_vhs;
   logic [7:0]  w_r1_base;
   logic [7:0]  w_r1;
   logic [39:0] w_resp;
   logic [5:0]  w_resp_len;
   logic        w_unused_bits;

   assign w_start    = (r_state == ST_IDLE) && !cs_n && !mosi;
   assign w_frame_ok = r_shift[46] && r_shift[0];
   assign w_idx      = r_shift[45:40];
   assign w_arg      = r_shift[39:8];
   assign w_busy     = r_busy_cnt < 8'(ACMD41_BUSY_CNT);
   assign w_acmd41   = (w_idx == ACMD41) && r_app_cmd;
   assign w_vhs      = (w_arg[11:8] == VHS_ACCEPT) ? w_arg[11:8] : 4'h0;
   assign w_r1_base  = {7'b0, r_in_idle};

`ifdef SD_RESP_CRC_CHECK_EN
   logic [6:0] w_crc;
   logic       w_crc_clr;
   logic       w_crc_en;

   // CRC covers frame bits 47..8, i.e. the first 40 bits received.
   assign w_crc_clr = (r_state == ST_IDLE);
   assign w_crc_en  = w_start || ((r_state == ST_RX_CMD) && (r_rx_cnt < 6'(FRAME_LEN - 8)));

   sd_crc7 u_crc7 (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_clr   (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (mosi),
      .o_crc   (w_crc)
   );

   assign w_crc_ok      = (w_crc == r_shift[7:1]);
   assign w_unused_bits = r_shift[47];
`else
   assign w_crc_ok      = 1'b1;
   assign w_unused_bits = ^{r_shift[47], r_shift[7:1]};
`endif

   always_comb begin
      w_r7 = 1'b0;
      w_r1 = w_r1_base;
      if (!w_crc_ok) begin
         w_r1 = w_r1_base | r1_bit(R1_CRC_ERR_BIT);
      end else if (w_idx == CMD0) begin
         w_r1 = r1_bit(R1_IDLE_BIT);
      end else if (w_idx == CMD8) begin
         w_r7 = 1'b1;
      end else if (w_idx == CMD55) begin
         w_r1 = w_r1_base;
      end else if (w_acmd41) begin
         w_r1 = w_busy ? r1_bit(R1_IDLE_BIT) : 8'h00;
      end else begin
         w_r1 = w_r1_base | r1_bit(R1_ILLEGAL_BIT);
      end
      w_resp     = w_r7 ? {w_r1, 16'h0000, 4'h0, w_vhs, w_arg[7:0]} : {w_r1, 32'h0};
      w_resp_len = w_r7 ? 6'(R7_LEN) : 6'(R1_LEN);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_rx_cnt     <= '0;
         r_ncr_cnt    <= '0;
         r_tx_cnt     <= '0;
         r_tx_len     <= '0;
         r_resp       <= '0;
         r_in_idle    <= 1'b1;
         r_app_cmd    <= 1'b0;
         r_busy_cnt   <= '0;
         r_miso       <= 1'b1;
         r_card_ready <= 1'b0;
         r_cmd_valid  <= 1'b0;
         r_cmd_index  <= '0;
         r_cmd_arg    <= '0;
      end else begin
         r_cmd_valid <= 1'b0;
         // Deselect abandons whatever is in flight; card state is left alone.
         if (cs_n && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_miso <= 1'b1;
                  if (w_start) begin
                     r_shift  <= {r_shift[46:0], mosi};
                     r_rx_cnt <= 6'd1;
                     r_state  <= ST_RX_CMD;
                  end
               end
               ST_RX_CMD: begin
                  r_shift  <= {r_shift[46:0], mosi};
                  r_rx_cnt <= r_rx_cnt + 6'd1;
                  if (r_rx_cnt == 6'(FRAME_LEN - 1)) begin
                     r_state <= ST_DECODE;
                  end
               end
               ST_DECODE: begin
                  if (w_frame_ok) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_index <= w_idx;
                     r_cmd_arg   <= w_arg;
                     r_resp      <= w_resp;
                     r_tx_len    <= w_resp_len;
                     r_ncr_cnt   <= '0;
                     r_state     <= ST_NCR_WAIT;
                     if (w_crc_ok) begin
                        r_app_cmd <= (w_idx == CMD55);
                        if (w_idx == CMD0) begin
                           r_in_idle    <= 1'b1;
                           r_busy_cnt   <= '0;
                           r_card_ready <= 1'b0;
                        end else if (w_acmd41) begin
                           if (w_busy) begin
                              r_busy_cnt <= r_busy_cnt + 8'd1;
                           end else begin
                              r_in_idle    <= 1'b0;
                              r_card_ready <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_NCR_WAIT: begin
                  if (r_ncr_cnt == 4'(NCR_CYCLES - 1)) begin
                     r_miso   <= r_resp[39];
                     r_resp   <= {r_resp[38:0], 1'b0};
                     r_tx_cnt <= 6'd1;
                     r_state  <= ST_TX_RESP;
                  end else begin
                     r_ncr_cnt <= r_ncr_cnt + 4'd1;
                  end
               end
               ST_TX_RESP: begin
                  if (r_tx_cnt == r_tx_len) begin
                     r_miso  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_miso   <= r_resp[39];
                     r_resp   <= {r_resp[38:0], 1'b0};
                     r_tx_cnt <= r_tx_cnt + 6'd1;
                  end
               end
               default: begin
                  r_miso  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign miso       = r_miso;
   assign card_ready = r_card_ready;
   assign cmd_valid  = r_cmd_valid;
   assign cmd_index  = r_cmd_index;
   assign cmd_arg    = r_cmd_arg;

endmodule
